nn_stage_ctrl_data_fifo_p: RTL and testbench

Parametrised stage data-FIFO controller for the neural pipeline. It sits between a stage's ready/valid input stream and an external single-port-write/single-port-read vector RAM. Incoming vectors are written into a circular set of slots. Each stored vector is then replayed twice: once for the forward pass and once for the error/update pass. A slot is freed only after its error replay, and the block emits a delayed `active` pipeline for the downstream MAC.

---
 rtl/nn_stage_ctrl_data_fifo_p.sv | 187 ++++++++++++++++++
 tb/tb_nn_stage_ctrl_data_fifo_p.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_stage_ctrl_data_fifo_p.sv
// nn_stage_ctrl_data_fifo_p: stage data-FIFO controller for the neural pipeline.
// Incoming vectors land in circular RAM slots. Each slot is replayed twice:
// once for the forward pass (FWD) and once for the error/update pass (ERR).
// A slot is released after its error replay. rd_en/rd_last/rd_err are also
// delayed by ACTIVE_DLY cycles to drive the downstream MAC.
// TAP_W must be >= LEN_W and ACTIVE_DLY must be >= 1.
module nn_stage_ctrl_data_fifo_p #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 4,
  parameter int DEPTH_W    = 6,
  parameter int TAP_W      = 5,
  parameter int ACTIVE_DLY = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LEN_W-1:0]         load_length,
  input  logic [DEPTH_W-1:0]       load_depth,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic                     err_req,
  output logic                     wr_en,
  output logic [DEPTH_W+LEN_W-1:0] wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     rd_en,
  output logic [DEPTH_W+LEN_W-1:0] rd_addr,
  output logic                     rd_last,
  output logic                     rd_err,
  output logic [TAP_W-1:0]         tap_address,
  output logic                     active,
  output logic                     active_last,
  output logic                     active_err,
  output logic [DEPTH_W:0]         occupancy,
  output logic [DEPTH_W:0]         pending
);

  localparam int OW = DEPTH_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  // One tap of the read-side delay line.
  typedef struct packed {
    logic en;
    logic last;
    logic err;
  } rd_tag_t;

  state_e                         state_q, state_d;
  logic [LEN_W-1:0]               wcnt_q, wcnt_d;
  logic [LEN_W-1:0]               rcnt_q, rcnt_d;
  logic [DEPTH_W-1:0]             wslot_q, wslot_d;
  logic [DEPTH_W-1:0]             fslot_q, fslot_d;
  logic [DEPTH_W-1:0]             eslot_q, eslot_d;
  logic [OW-1:0]                  occ_q, occ_d;
  logic [OW-1:0]                  pend_q, pend_d;
  logic [OW-1:0]                  retained;
  logic                           err_pend_q, err_pend_d;
  rd_tag_t [ACTIVE_DLY-1:0]       dly_q, dly_d;

  logic wr_done;
  logic fwd_done;
  logic err_done;
  logic enter_err;

  // Slot pointers wrap at the configured depth, not at 2^DEPTH_W.
  function automatic logic [DEPTH_W-1:0] slot_inc(input logic [DEPTH_W-1:0] s,
                                                  input logic [DEPTH_W-1:0] lim);
    return (s == lim) ? '0 : s + DEPTH_W'(1);
  endfunction

  // Write side: handshake, RAM write strobe and write beat/slot counters.
  always_comb begin
    in_rdy  = (occ_q <= {1'b0, load_depth});
    wr_en   = in_vld & in_rdy;
    wr_data = in_data;
    wr_addr = {wslot_q, wcnt_q};
    wr_done = wr_en && (wcnt_q == load_length);
    wcnt_d  = wcnt_q;
    wslot_d = wslot_q;
    if (wr_en) begin
      if (wr_done) begin
        wcnt_d  = '0;
        wslot_d = slot_inc(wslot_q, load_depth);
      end else begin
        wcnt_d  = wcnt_q + LEN_W'(1);
      end
    end
  end

  // Read strobes decoded straight from the FSM state and beat counter.
  always_comb begin
    rd_en       = (state_q != S_IDLE);
    rd_err      = (state_q == S_ERR);
    rd_last     = rd_en && (rcnt_q == load_length);
    fwd_done    = rd_last & ~rd_err;
    err_done    = rd_last & rd_err;
    rd_addr     = '0;
    tap_address = '0;
    if (rd_en) begin
      rd_addr     = {(rd_err ? eslot_q : fslot_q), rcnt_q};
      tap_address = TAP_W'(rcnt_q);
    end
  end

  // Slot accounting, replay pointers and the read beat counter.
  always_comb begin
    occ_d  = occ_q;
    pend_d = pend_q;
    if (wr_done && !err_done)      occ_d = occ_q + OW'(1);
    else if (!wr_done && err_done) occ_d = occ_q - OW'(1);
    if (wr_done && !fwd_done)      pend_d = pend_q + OW'(1);
    else if (!wr_done && fwd_done) pend_d = pend_q - OW'(1);
    // Slots already forward-read and waiting for their error replay.
    retained = occ_q - pend_q;
    rcnt_d   = rcnt_q;
    if (rd_en) rcnt_d = rd_last ? '0 : rcnt_q + LEN_W'(1);
    fslot_d  = fwd_done ? slot_inc(fslot_q, load_depth) : fslot_q;
    eslot_d  = err_done ? slot_inc(eslot_q, load_depth) : eslot_q;
  end

  // Replay FSM next state; forward replays always win over error replays.
  always_comb begin
    state_d   = state_q;
    enter_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_FWD;
        end else if (err_pend_q && (retained != '0)) begin
          state_d   = S_ERR;
          enter_err = 1'b1;
        end
      end
      S_FWD:   if (rd_last) state_d = (pend_d != '0) ? S_FWD : S_IDLE;
      S_ERR:   if (rd_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Requests merge into one sticky flag; a request arriving on the
    // entry cycle is kept and serviced by a later replay.
    err_pend_d = err_req | (err_pend_q & ~enter_err);
  end

  // Delay line that turns the read strobes into the MAC active pipeline.
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = {rd_en, rd_last, rd_err};
    for (int i = 1; i < ACTIVE_DLY; i++) dly_d[i] = dly_q[i-1];
  end

  assign active      = dly_q[ACTIVE_DLY-1].en;
  assign active_last = dly_q[ACTIVE_DLY-1].last;
  assign active_err  = dly_q[ACTIVE_DLY-1].err;
  assign occupancy   = occ_q;
  assign pending     = pend_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      wslot_q    <= '0;
      fslot_q    <= '0;
      eslot_q    <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      err_pend_q <= 1'b0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      wslot_q    <= wslot_d;
      fslot_q    <= fslot_d;
      eslot_q    <= eslot_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      err_pend_q <= err_pend_d;
      dly_q      <= dly_d;
    end
  end

endmodule

// File: tb/tb_nn_stage_ctrl_data_fifo_p.sv
// Directed bench for nn_stage_ctrl_data_fifo_p: per-cycle vector tables for
// the streaming scenarios plus hand-written multi-cycle corner sequences.
module tb_nn_stage_ctrl_data_fifo_p;

  logic        clk;
  logic        reset;
  logic [3:0]  load_length;
  logic [5:0]  load_depth;
  logic [31:0] in_data;
  logic        in_vld;
  logic        in_rdy;
  logic        err_req;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic        rd_last;
  logic        rd_err;
  logic [4:0]  tap_address;
  logic        active;
  logic        active_last;
  logic        active_err;
  logic [6:0]  occupancy;
  logic [6:0]  pending;

  int n_chk  = 0;
  int n_pass = 0;

  nn_stage_ctrl_data_fifo_p #(
    .DATA_W(32), .LEN_W(4), .DEPTH_W(6), .TAP_W(5), .ACTIVE_DLY(18)
  ) dut (
    .clk(clk), .reset(reset), .load_length(load_length), .load_depth(load_depth),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy), .err_req(err_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_last(rd_last), .rd_err(rd_err),
    .tap_address(tap_address), .active(active), .active_last(active_last),
    .active_err(active_err), .occupancy(occupancy), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One cycle of stimulus and expected outputs.
  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        err;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic        rdy;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        rd_last;
    logic        rd_err;
    logic [4:0]  tap;
    logic        act;
    logic        alast;
    logic [6:0]  pend;
    logic [6:0]  occ;
  } vec_t;

  vec_t tbl [0:63];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_vld  = 1'b0;
    err_req = 1'b0;
    in_data = '0;
    adv();
    adv();
    reset = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, ".in_rdy"},      32'(in_rdy),      32'd1);
    chk({tag, ".wr_en"},       32'(wr_en),       32'd0);
    chk({tag, ".wr_addr"},     32'(wr_addr),     32'd0);
    chk({tag, ".rd_en"},       32'(rd_en),       32'd0);
    chk({tag, ".rd_addr"},     32'(rd_addr),     32'd0);
    chk({tag, ".rd_last"},     32'(rd_last),     32'd0);
    chk({tag, ".rd_err"},      32'(rd_err),      32'd0);
    chk({tag, ".tap"},         32'(tap_address), 32'd0);
    chk({tag, ".active"},      32'(active),      32'd0);
    chk({tag, ".active_last"}, 32'(active_last), 32'd0);
    chk({tag, ".active_err"},  32'(active_err),  32'd0);
    chk({tag, ".occupancy"},   32'(occupancy),   32'd0);
    chk({tag, ".pending"},     32'(pending),     32'd0);
    adv();
  endtask

  // Table fill helpers: all vectors are 4 beats long (load_length = 3).
  task automatic tclr(input int n);
    for (int i = 0; i < n; i++) begin
      tbl[i]     = '{default: '0};
      tbl[i].rdy = 1'b1;
    end
  endtask

  task automatic twr(input int r0, input int slot, input int base);
    for (int k = 0; k < 4; k++) begin
      tbl[r0+k].vld     = 1'b1;
      tbl[r0+k].data    = 32'(base + k);
      tbl[r0+k].wr_en   = 1'b1;
      tbl[r0+k].wr_addr = 10'(slot * 16 + k);
    end
  endtask

  task automatic trd(input int r0, input int slot, input logic e);
    for (int k = 0; k < 4; k++) begin
      tbl[r0+k].rd_en   = 1'b1;
      tbl[r0+k].rd_addr = 10'(slot * 16 + k);
      tbl[r0+k].tap     = 5'(k);
      tbl[r0+k].rd_err  = e;
      tbl[r0+k].rd_last = (k == 3);
    end
  endtask

  task automatic tpo(input int a, input int b, input int p, input int o);
    for (int i = a; i <= b; i++) begin
      tbl[i].pend = 7'(p);
      tbl[i].occ  = 7'(o);
    end
  endtask

  task automatic run_tbl(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      in_vld  = tbl[i].vld;
      in_data = tbl[i].data;
      err_req = tbl[i].err;
      @(negedge clk);
      chk($sformatf("%s[%0d].wr_en", tag, i), 32'(wr_en), 32'(tbl[i].wr_en));
      if (tbl[i].wr_en) begin
        chk($sformatf("%s[%0d].wr_addr", tag, i), 32'(wr_addr), 32'(tbl[i].wr_addr));
        chk($sformatf("%s[%0d].wr_data", tag, i), wr_data, tbl[i].data);
      end
      chk($sformatf("%s[%0d].in_rdy", tag, i), 32'(in_rdy), 32'(tbl[i].rdy));
      chk($sformatf("%s[%0d].rd_en", tag, i), 32'(rd_en), 32'(tbl[i].rd_en));
      if (tbl[i].rd_en)
        chk($sformatf("%s[%0d].rd_addr", tag, i), 32'(rd_addr), 32'(tbl[i].rd_addr));
      chk($sformatf("%s[%0d].rd_last", tag, i), 32'(rd_last), 32'(tbl[i].rd_last));
      chk($sformatf("%s[%0d].rd_err", tag, i), 32'(rd_err), 32'(tbl[i].rd_err));
      chk($sformatf("%s[%0d].tap", tag, i), 32'(tap_address), 32'(tbl[i].tap));
      chk($sformatf("%s[%0d].active", tag, i), 32'(active), 32'(tbl[i].act));
      chk($sformatf("%s[%0d].active_last", tag, i), 32'(active_last), 32'(tbl[i].alast));
      chk($sformatf("%s[%0d].pending", tag, i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("%s[%0d].occupancy", tag, i), 32'(occupancy), 32'(tbl[i].occ));
      adv();
    end
    in_vld  = 1'b0;
    err_req = 1'b0;
  endtask

  initial begin
    int act_seen;
    load_length = 4'd3;
    load_depth  = 6'd1;

    // Reset values, then basic write of one vector and its forward replay.
    do_reset();
    chk_reset("reset");
    tclr(28);
    twr(0, 0, 100);
    trd(5, 0, 1'b0);
    tpo(0, 3, 0, 0);
    tpo(4, 8, 1, 1);
    tpo(9, 27, 0, 1);
    for (int i = 23; i <= 26; i++) tbl[i].act = 1'b1;
    tbl[26].alast = 1'b1;
    run_tbl("basic", 28);

    // Full stall with 2 slots, then two error replays releasing the slots.
    do_reset();
    tclr(30);
    twr(0, 0, 200);
    twr(4, 1, 204);
    for (int i = 8; i <= 11; i++) begin
      tbl[i].vld  = 1'b1;
      tbl[i].data = 32'(200 + i);
    end
    for (int i = 8; i <= 21; i++) tbl[i].rdy = 1'b0;
    trd(5, 0, 1'b0);
    trd(9, 1, 1'b0);
    trd(18, 0, 1'b1);
    trd(25, 1, 1'b1);
    tbl[16].err = 1'b1;
    tbl[23].err = 1'b1;
    tpo(0, 3, 0, 0);
    tpo(4, 7, 1, 1);
    tpo(8, 8, 2, 2);
    tpo(9, 12, 1, 2);
    tpo(13, 21, 0, 2);
    tpo(22, 28, 0, 1);
    tpo(29, 29, 0, 0);
    for (int i = 23; i <= 29; i++) tbl[i].act = 1'b1;
    tbl[26].alast = 1'b1;
    run_tbl("stall", 30);

    // Write completion coinciding with FWD rd_last, then with ERR rd_last.
    do_reset();
    load_depth = 6'd3;
    tclr(21);
    twr(0, 0, 300);
    twr(5, 1, 310);
    twr(15, 2, 320);
    trd(5, 0, 1'b0);
    trd(9, 1, 1'b0);
    trd(15, 0, 1'b1);
    tbl[20].rd_en   = 1'b1;
    tbl[20].rd_addr = 10'd32;
    tbl[13].err     = 1'b1;
    tpo(0, 3, 0, 0);
    tpo(4, 8, 1, 1);
    tpo(9, 12, 1, 2);
    tpo(13, 18, 0, 2);
    tpo(19, 20, 1, 2);
    run_tbl("simul", 21);

    // Error request while forward replays are pending is held back.
    do_reset();
    for (int p = 0; p < 36; p++) begin
      in_vld  = (p < 8);
      in_data = 32'(400 + p);
      err_req = (p == 6);
      @(negedge clk);
      if (p == 8) begin
        chk("prio.pending_at_8", 32'(pending), 32'd2);
        chk("prio.rd_last_at_8", 32'(rd_last), 32'd1);
      end
      if (p == 10) begin
        chk("prio.rd_en_at_10", 32'(rd_en), 32'd1);
        chk("prio.rd_err_at_10", 32'(rd_err), 32'd0);
        chk("prio.rd_addr_at_10", 32'(rd_addr), 32'd17);
      end
      if (p == 13) chk("prio.idle_gap_at_13", 32'(rd_en), 32'd0);
      if (p == 14) begin
        chk("prio.rd_err_at_14", 32'(rd_err), 32'd1);
        chk("prio.rd_addr_at_14", 32'(rd_addr), 32'd0);
      end
      if (p == 18) begin
        chk("prio.occupancy_at_18", 32'(occupancy), 32'd1);
        chk("prio.in_rdy_at_18", 32'(in_rdy), 32'd1);
      end
      if (p == 31) chk("prio.active_err_at_31", 32'(active_err), 32'd0);
      if (p == 32) begin
        chk("prio.active_err_at_32", 32'(active_err), 32'd1);
        chk("prio.active_at_32", 32'(active), 32'd1);
      end
      adv();
    end
    in_vld = 1'b0;

    // Error request with nothing retained waits until a forward replay.
    do_reset();
    load_depth = 6'd1;
    for (int u = 0; u < 20; u++) begin
      err_req = (u == 0);
      in_vld  = (u >= 6 && u <= 9);
      in_data = 32'(500 + u);
      @(negedge clk);
      if (u <= 5) chk($sformatf("ret0.no_read_at_%0d", u), 32'(rd_en), 32'd0);
      if (u == 15) chk("ret0.idle_at_15", 32'(rd_en), 32'd0);
      if (u == 16) begin
        chk("ret0.rd_err_at_16", 32'(rd_err), 32'd1);
        chk("ret0.rd_addr_at_16", 32'(rd_addr), 32'd0);
      end
      adv();
    end
    in_vld  = 1'b0;
    err_req = 1'b0;

    // Reset during a forward replay at rcnt = 2.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      in_vld  = (r < 4);
      in_data = 32'(600 + r);
      if (r == 7) begin
        in_vld = 1'b0;
        reset  = 1'b1;
      end
      @(negedge clk);
      if (r == 7) chk("rstmid.tap_before", 32'(tap_address), 32'd2);
      adv();
    end
    reset = 1'b0;
    chk_reset("rstmid");
    act_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (active || active_last || active_err || rd_en) act_seen++;
      adv();
    end
    chk("rstmid.no_activity_after", 32'(act_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
